mem_responder: RTL
==================

# mem_responder

Memory-side responder for the accumulator processor's multicycle control unit. It accepts memory commands issued by the control FSM (address source select, write enable, write-data source select), performs the access on an internal word-addressed RAM after a configurable number of wait states, and returns read data with a one-cycle ready pulse. The control unit holds its current state until the ready pulse arrives, which lets the datapath run against slow memory.

## Interface
- AW, 10, word-address width; RAM depth is 2^AW words
- DW, 16, data and address-input width
- WAIT, 1, wait-state cycles inserted before each access; legal range 0..15
- CLK  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high
- MemReq  input  1  request strobe from control; sampled only in IDLE or DONE
- MemWrite  input  1  1 = write, 0 = read
- MemAddr  input  2  address source: 00 PC, 01 Imm, 10 SP, 11 ALUOut
- MemData  input  1  write-data source: 0 ACC, 1 PC (return address for jal)
- PC, Imm, SP, ALUOut  input  DW each  candidate addresses (Imm zero-extended upstream)
- ACC  input  DW  accumulator value
- ReadData  output  DW  registered read result
- MemReady  output  1  one-cycle completion pulse
- Busy  output  1  high while a request is in flight
- AddrErr  output  1  out-of-range flag, valid with MemReady

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE/DONE + MemReq=1: latch the selected address, the selected write data, and MemWrite. Next state is WAIT if WAIT>0, otherwise ACCESS. Load the 4-bit wait counter with WAIT.
- IDLE/DONE + MemReq=0: next state is IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACCESS. The design spends exactly WAIT cycles in WAIT.
- ACCESS: one cycle. At the closing edge:
  - write: RAM[addr[AW-1:0]] updated.
  - read: ReadData loaded.
  - Next state is DONE.
- DONE: one cycle, MemReady=1. A new request may be accepted in this cycle (back-to-back).
- Out of range: the latched address has any bit [DW-1:AW] set.
  - A write is suppressed.
  - A read loads ReadData=0.
  - AddrErr=1 during DONE.
- ReadData holds its value on writes and between requests. It changes only at the ACCESS edge of a read.
- MemReq in WAIT/ACCESS: ignored. There is no queueing, and the latched inputs do not change.
- Address and data inputs are sampled only at acceptance. Changing them afterwards has no effect.
- Reading the same address after a write returns the newly written value.

## Timing
- Reset values: state IDLE; ReadData=0, MemReady=0, Busy=0, AddrErr=0, counter=0. RAM contents are not reset.
- Request sampled at the end of cycle 0:
  - Cycles 1..WAIT: WAIT state.
  - Cycle WAIT+1: ACCESS.
  - Cycle WAIT+2: DONE, MemReady=1, ReadData valid.
- Latency is WAIT+2 cycles from the request cycle to MemReady.
- Back-to-back throughput is one access per WAIT+2 cycles.
- Busy=1 in WAIT and ACCESS; Busy=0 in IDLE and DONE.
- MemReady and AddrErr are high for exactly one cycle per request. They are driven from state, not directly from inputs.
- Reset asserted mid-operation:
  - Returns to IDLE immediately and clears all outputs.
  - Discards a pending write; the RAM is written only on an ACCESS edge with Reset low.
  - Deasserting Reset resumes in IDLE.

## Test plan
- WAIT=1, write: MemReq, MemWrite=1, MemAddr=01, Imm=0x0005, MemData=0, ACC=0xBEEF. Then a read with MemAddr=01. Required: read MemReady appears 3 cycles after its request cycle, ReadData=0xBEEF, AddrErr=0.
- Jal-style write: MemAddr=10, SP=0x03FE, MemData=1, PC=0x0124, then a read of the same address. Required: ReadData=0x0124. ReadData stays at its prior value through the write's DONE cycle.
- Back-to-back with WAIT=0:
  - MemReq held high over 3 reads of ALUOut=0x10, 0x11, 0x12.
  - Required: MemReady pulses every 2 cycles and Busy toggles 1,0,1,0.
  - MemReq pulses during ACCESS are ignored.
- Out of range, AW=10: write ACC=0x1234 to ALUOut=0x0405, then read 0x0005. Required: AddrErr=1 with the write's MemReady, RAM[5] unchanged. A direct read of 0x0405 returns ReadData=0 with AddrErr=1.
- Reset abort, WAIT=3: assert Reset during the 2nd WAIT cycle of a write of 0xAAAA to 0x0007. Required: all outputs 0 immediately, then a read of 0x0007 returns the old value.
- Input change after acceptance: alter PC, Imm, SP, ALUOut and ACC during WAIT. Required: access uses the values captured at acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word RAM that serves control-unit memory commands and pulses MemReady on completion
module mem_responder #(
  parameter int AW = 10,
  parameter int DW = 16,
  parameter int WAIT = 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          MemReq,
  input  logic          MemWrite,
  input  logic [1:0]    MemAddr,
  input  logic          MemData,
  input  logic [DW-1:0] PC,
  input  logic [DW-1:0] Imm,
  input  logic [DW-1:0] SP,
  input  logic [DW-1:0] ALUOut,
  input  logic [DW-1:0] ACC,
  output logic [DW-1:0] ReadData,
  output logic          MemReady,
  output logic          Busy,
  output logic          AddrErr
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [DW-1:0] addr, wdata, sel_addr;
  logic we, oor, accept;
  logic [DW-1:0] ram [2**AW];
  assign accept = (state == S_IDLE || state == S_DONE) && MemReq;
  assign sel_addr = MemAddr == 2'd0 ? PC : MemAddr == 2'd1 ? Imm : MemAddr == 2'd2 ? SP : ALUOut;
  assign oor = |addr[DW-1:AW];
  assign MemReady = state == S_DONE;
  assign Busy = state == S_WAIT || state == S_ACCESS;
  assign AddrErr = state == S_DONE && oor;
  always_comb begin
    state_nx = accept ? (WAIT > 0 ? S_WAIT : S_ACCESS)
             : state == S_WAIT ? (cnt == 4'd1 ? S_ACCESS : S_WAIT)
             : state == S_ACCESS ? S_DONE : S_IDLE;
    cnt_nx = accept ? 4'(WAIT) : state == S_WAIT ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      we <= 1'b0;
      ReadData <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        addr <= sel_addr;
        wdata <= MemData ? PC : ACC;
        we <= MemWrite;
      end
      if (state == S_ACCESS && !we) ReadData <= oor ? '0 : ram[addr[AW-1:0]];
    end
  end
  // RAM is deliberately left unreset; an aborted write never reaches ACCESS
  always_ff @(posedge CLK) begin
    if (state == S_ACCESS && we && !oor && !Reset) ram[addr[AW-1:0]] <= wdata;
  end
endmodule
